rr_bus_arbiter: RTL and testbench

- Four-requester round-robin arbiter that shares one bus or datapath resource between four masters.
- Drives a one-hot grant vector, the 2-to-4 decoded form of the registered grant index, plus the binary index for mux select.
- Holds a grant until the owner releases it, or until a hold-time limit forces release.
- Sits between the requesting units and the shared resource's select/enable logic.

---
 rtl/rr_bus_arbiter.sv | 98 +++++++++
 tb/tb_rr_bus_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// Four-master round-robin bus arbiter with owner-held grants, an optional
// hold-time limit that forces release, and a per-master lockout after a forced release.
module rr_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [3:0] blocked
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic             HOLD_EN   = (MAX_HOLD != 0);

  logic             state;
  logic [1:0]       last;
  logic [CNT_W-1:0] hold_cnt;

  logic [3:0] elig;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       pick_ok;
  logic       owner_rel;
  logic       forced;
  logic [3:0] blk_set;

  // Search starts one past the last owner and wraps, so the last owner ranks lowest.
  always_comb begin
    elig    = req & ~blocked;
    pick    = '0;
    cand    = '0;
    pick_ok = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!pick_ok && elig[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  // Forced release needs req still high, so it can never coincide with an owner release.
  always_comb begin
    owner_rel = (state == ST_BUSY) && !req[gnt_idx];
    forced    = (state == ST_BUSY) && req[gnt_idx] && HOLD_EN && (hold_cnt == HOLD_LAST);
    blk_set   = '0;
    if (forced) blk_set[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last      <= 2'd3;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      blocked   <= '0;
    end else begin
      timeout <= 1'b0;
      blocked <= (blocked & req) | blk_set;
      case (state)
        ST_IDLE: begin
          if (pick_ok) begin
            state     <= ST_BUSY;
            gnt_idx   <= pick;
            gnt       <= 4'b0001 << pick;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        default: begin
          if (owner_rel || forced) begin
            state     <= ST_IDLE;
            last      <= gnt_idx;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= forced;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed-vector bench for rr_bus_arbiter with a short hold limit (MAX_HOLD=4).
module tb_rr_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic [3:0] blocked;

  int unsigned total;
  int unsigned bad;

  rr_bus_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .blocked   (blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       to;
    logic [3:0] blk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i,
                     input logic v, input logic t, input logic [3:0] b);
    vec_t x;
    x.req = r; x.gnt = g; x.idx = i; x.vld = v; x.to = t; x.blk = b;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] i,
                       input logic v, input logic t, input logic [3:0] b);
    logic ok;
    total++;
    ok = (gnt === g) && (gnt_valid === v) && (timeout === t) && (blocked === b) &&
         (!v || (gnt_idx === i));
    if (!ok) begin
      bad++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b blk=%b, want gnt=%b idx=%0d vld=%b to=%b blk=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, blocked, g, i, v, t, b);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // round robin, each owner holds 3 cycles then drops req for one
    add(4'b1111, 4'b0001, 2'd0, 1, 0, 4'b0000);
    add(4'b1111, 4'b0001, 2'd0, 1, 0, 4'b0000);
    add(4'b1111, 4'b0001, 2'd0, 1, 0, 4'b0000);
    add(4'b1110, 4'b0000, 2'd0, 0, 0, 4'b0000);
    add(4'b1111, 4'b0010, 2'd1, 1, 0, 4'b0000);
    add(4'b1111, 4'b0010, 2'd1, 1, 0, 4'b0000);
    add(4'b1111, 4'b0010, 2'd1, 1, 0, 4'b0000);
    add(4'b1101, 4'b0000, 2'd0, 0, 0, 4'b0000);
    add(4'b1111, 4'b0100, 2'd2, 1, 0, 4'b0000);
    add(4'b1111, 4'b0100, 2'd2, 1, 0, 4'b0000);
    add(4'b1111, 4'b0100, 2'd2, 1, 0, 4'b0000);
    add(4'b1011, 4'b0000, 2'd0, 0, 0, 4'b0000);
    add(4'b1111, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b1111, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b1111, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b0111, 4'b0000, 2'd0, 0, 0, 4'b0000);
    add(4'b1111, 4'b0001, 2'd0, 1, 0, 4'b0000);
    add(4'b1110, 4'b0000, 2'd0, 0, 0, 4'b0000);
    add(4'b1111, 4'b0010, 2'd1, 1, 0, 4'b0000);
    add(4'b1101, 4'b0000, 2'd0, 0, 0, 4'b0000);
    add(4'b1111, 4'b0100, 2'd2, 1, 0, 4'b0000);
    add(4'b1011, 4'b0000, 2'd0, 0, 0, 4'b0000);
    // wrap past 3 and 0 to master 1, then go idle
    add(4'b0010, 4'b0010, 2'd1, 1, 0, 4'b0000);
    add(4'b0000, 4'b0000, 2'd0, 0, 0, 4'b0000);
    add(4'b0000, 4'b0000, 2'd0, 0, 0, 4'b0000);
    // master 3 times out after 4 cycles and stays locked out while req[3] high
    add(4'b1000, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b1000, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b1000, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b1000, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b1000, 4'b0000, 2'd0, 0, 1, 4'b1000);
    add(4'b1000, 4'b0000, 2'd0, 0, 0, 4'b1000);
    add(4'b1000, 4'b0000, 2'd0, 0, 0, 4'b1000);
    add(4'b0000, 4'b0000, 2'd0, 0, 0, 4'b0000);
    add(4'b1000, 4'b1000, 2'd3, 1, 0, 4'b0000);
    // others ignored while busy; owner drops req on the limit cycle
    add(4'b1100, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b1100, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b1100, 4'b1000, 2'd3, 1, 0, 4'b0000);
    add(4'b0100, 4'b0000, 2'd0, 0, 0, 4'b0000);
    add(4'b0100, 4'b0100, 2'd2, 1, 0, 4'b0000);

    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (2) @(posedge clk);
    #1 check("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
    total++;
    if (gnt_idx !== 2'd0) begin
      bad++;
      $display("FAIL reset_idx: got %0d want 0", gnt_idx);
    end

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req = vecs[i].req;
      @(posedge clk);
      #1 check($sformatf("row%0d", i + 1), vecs[i].gnt, vecs[i].idx, vecs[i].vld,
               vecs[i].to, vecs[i].blk);
    end

    // asynchronous reset between edges while master 2 owns the bus
    #2 rst_n = 1'b0;
    #1 check("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    #1 check("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0100;
    @(posedge clk);
    #1 check("post_rst", 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
